mux2_rr_arbiter: RTL

Two-input round-robin scheduler for the 8-bit 2:1 mux path. It buffers each requester stream in its own small FIFO and decides each cycle which stream owns the shared output. It drives the mux selector and presents one registered valid/ready output stream downstream. It sits between the two upstream producers and the consumer of the muxed byte stream, and replaces free-running selector control.

---
 rtl/mux2_rr_arbiter_pkg.sv | 7 +
 rtl/mux2_rr_arbiter_sync_fifo.sv | 40 ++++
 rtl/mux2_rr_arbiter.sv | 69 ++++++
 3 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// mux2_rr_arbiter_pkg: shared widths, defaults and grant-state encoding for the 2:1 round-robin mux.
package mux2_rr_arbiter_pkg;
  localparam int DATA_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AF_LEVEL = 3;
  typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} grant_state_t;
endpackage

// File: rtl/mux2_rr_arbiter_sync_fifo.sv
// sync_fifo: single-clock FIFO; full/empty decisions use the start-of-cycle count.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= (AW+1)'(AF_LEVEL);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two buffered requesters sharing one registered valid/ready byte stream,
// granted round-robin with requester 0 winning the first tie.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic              almost_full0,
  output logic              almost_full1,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              selector,
  output logic [1:0]        overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [DATA_W-1:0] dout0, dout1;
  logic [CW-1:0] cnt0, cnt1;
  logic full0, full1, empty0, empty1;
  logic elig0, elig1, load, grant_any, gnt, pop0, pop1;
  grant_state_t state, state_n;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo0 (
    .clk(clk), .reset(reset), .push(valid_in0), .pop(pop0), .din(data_in0), .dout(dout0),
    .count(cnt0), .full(full0), .empty(empty0), .almost_full(almost_full0)
  );
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo1 (
    .clk(clk), .reset(reset), .push(valid_in1), .pop(pop1), .din(data_in1), .dout(dout1),
    .count(cnt1), .full(full1), .empty(empty1), .almost_full(almost_full1)
  );

  // A tie goes to the requester not named by the state; otherwise the only eligible one wins.
  always_comb begin
    load = !valid_out || ready_out;
    elig0 = !empty0 && cnt0 != '0;
    elig1 = !empty1 && cnt1 != '0;
    grant_any = load && (elig0 || elig1);
    gnt = (elig0 && elig1) ? (state == LAST0) : elig1;
    pop0 = grant_any && !gnt;
    pop1 = grant_any && gnt;
    state_n = grant_any ? grant_state_t'(gnt) : state;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= LAST1;
    else state <= state_n;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_out <= '0;
      valid_out <= 1'b0;
      selector <= 1'b0;
      overflow <= 2'b00;
    end else begin
      if (load) valid_out <= grant_any;
      if (grant_any) begin
        data_out <= gnt ? dout1 : dout0;
        selector <= gnt;
      end
      overflow <= overflow | {valid_in1 && full1, valid_in0 && full0};
    end
endmodule
